// File: rtl/button_defs_pkg.sv
// rtl/button_defs_pkg.sv - shared state encodings and defaults for the pushbutton debouncer
package button_defs;

   localparam int DEFAULT_DB_CYCLES = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      CHK_PRESS = 2'b01,
      HELD      = 2'b10,
      CHK_REL   = 2'b11
   } state_t;

endpackage

// File: rtl/button_debounce_sync2.sv
// rtl/button_debounce_sync2.sv - two-flop synchronizer for an asynchronous level input
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced button level with registered press/release pulses
module button_debounce
   import button_defs::*;
#(
   parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic button,
   output logic pressed,
   output logic released
);

   localparam int CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          s;
   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          button_nx, pressed_nx, released_nx;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw),
      .q   (s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         button   <= 1'b0;
         pressed  <= 1'b0;
         released <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         button   <= button_nx;
         pressed  <= pressed_nx;
         released <= released_nx;
      end
   end

   // Outputs are registered from the next state so button moves on the same edge as the FSM.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (s) begin
               state_nx = CHK_PRESS;
               cnt_nx   = CW'(1);
            end
         end
         CHK_PRESS: begin
            if (!s) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt >= CNT_LAST) begin
               state_nx = HELD;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         HELD: begin
            cnt_nx = '0;
            if (!s) begin
               state_nx = CHK_REL;
               cnt_nx   = CW'(1);
            end
         end
         CHK_REL: begin
            if (s) begin
               state_nx = HELD;
               cnt_nx   = '0;
            end else if (cnt >= CNT_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      button_nx   = (state_nx == HELD) || (state_nx == CHK_REL);
      pressed_nx  = (state == CHK_PRESS) && (state_nx == HELD);
      released_nx = (state == CHK_REL) && (state_nx == IDLE);
   end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed vector bench for button_debounce with DB_CYCLES=4
module tb_button_debounce;

   typedef struct {
      logic rst;
      logic raw;
      logic b;
      logic p;
      logic r;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic raw;
   logic button, pressed, released;

   int tests = 0;
   int fails = 0;
   vec_t vecs[$];

   button_debounce #(.DB_CYCLES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw),
      .button   (button),
      .pressed  (pressed),
      .released (released)
   );

   always #1 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic void add(logic r_st, logic r_aw, logic eb, logic ep, logic er, int n);
      for (int k = 0; k < n; k++) vecs.push_back('{r_st, r_aw, eb, ep, er});
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(string name, int idx, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %0b expected %0b", name, idx, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int n_press, n_rel, at_press, waited;
      logic [7:0] hist;
      logic seg_lvl;

      rst = 1'b1;
      raw = 1'b0;
      @(negedge clk);

      // reset, clean press (40 ns), release, 3-cycle glitch
      add(1, 0, 0, 0, 0, 2);
      add(0, 0, 0, 0, 0, 3);
      add(0, 1, 0, 0, 0, 5);
      add(0, 1, 1, 1, 0, 1);
      add(0, 1, 1, 0, 0, 14);
      add(0, 0, 1, 0, 0, 5);
      add(0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 4);
      add(0, 1, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0, 8);

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         raw = vecs[i].raw;
         tick();
         check("vec_button", i, button, vecs[i].b);
         check("vec_pressed", i, pressed, vecs[i].p);
         check("vec_released", i, released, vecs[i].r);
      end

      // bounce 1,0,1,0 then steady 1
      raw = 1'b1; tick();
      raw = 1'b0; tick();
      raw = 1'b1; tick();
      raw = 1'b0; tick();
      raw = 1'b1;
      n_press = 0; n_rel = 0; at_press = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (pressed) begin
            n_press++;
            at_press = i;
         end
         if (released) n_rel++;
      end
      check_int("bounce_press_count", n_press, 1);
      check_int("bounce_press_edge", at_press, 6);
      check_int("bounce_release_count", n_rel, 0);
      check("bounce_button", 0, button, 1'b1);

      // reset while held with raw still high
      rst = 1'b1;
      tick();
      check("rst_held_button", 0, button, 1'b0);
      check("rst_held_released", 0, released, 1'b0);
      check("rst_held_pressed", 0, pressed, 1'b0);
      rst = 1'b0;
      n_press = 0; n_rel = 0; at_press = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (pressed) begin
            n_press++;
            at_press = i;
         end
         if (released) n_rel++;
      end
      check_int("rst_repress_count", n_press, 1);
      check_int("rst_repress_edge", at_press, 6);
      check_int("rst_no_release", n_rel, 0);

      // settle low, bounded
      raw = 1'b0;
      waited = 0;
      while (button && waited < 20) begin
         tick();
         waited++;
      end
      check("settle_low", 0, button, 1'b0);
      for (int i = 0; i < 8; i++) tick();

      // chain pattern 50/50/50/50/100 ns; reference is raw delayed six edges
      hist = '0;
      n_press = 0; n_rel = 0;
      for (int i = 0; i < 170; i++) begin
         if (i < 125) seg_lvl = ((i / 25) % 2) == 0;
         else seg_lvl = (i < 150);
         raw = seg_lvl;
         tick();
         hist = {hist[6:0], seg_lvl};
         check("chain_button", i, button, hist[5]);
         check("chain_pressed", i, pressed, hist[5] & ~hist[6]);
         check("chain_released", i, released, ~hist[5] & hist[6]);
         if (pressed && released) check("chain_exclusive", i, 1'b1, 1'b0);
         if (pressed) n_press++;
         if (released) n_rel++;
      end
      check_int("chain_press_count", n_press, 3);
      check_int("chain_release_count", n_rel, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
